layer_sequencer: RTL and testbench
==================================

LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; the port list SHALL be as given in REQ-002..REQ-014.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cfg_we  in  1  layer-table write strobe.
REQ-005 cfg_addr  in  5  layer-table entry index, 0..31.
REQ-006 cfg_type  in  2  layer type: 01 CONV, 10 DENSE, 11 POOL, 00 invalid.
REQ-007 num_layers  in  6  layers to run, 0..32; values >32 SHALL be treated as 32.
REQ-008 first_buf1  in  1  1: layer 0 reads from BUF1 (ping); 0: layer 0 reads from BUF2 (pong).
REQ-009 start  in  1  single-cycle run request.
REQ-010 layer_done  in  1  single-cycle completion pulse from the active conv/dense/pool controller.
REQ-011 comp_sel  out  3  compute select for the buffer/PE-array mux: 000 idle, 001 conv, 010 dense, 011 pool.
REQ-012 aybz_azby  out  2  ping-pong routing code: conv/pool 01 ping, 00 pong; dense 11 ping, 10 pong.
REQ-013 layer_start  out  1  one-cycle pulse that launches the selected controller.
REQ-014 layer_idx (out, 5) current layer; busy (out, 1); done (out, 1, pulse); error (out, 1, sticky); timeout (out, 1, sticky).

Function
REQ-015 The layer table SHALL be 32x2 bits; a write SHALL occur only when cfg_we=1 and busy=0; writes while busy SHALL be ignored.
REQ-016 The FSM SHALL have states IDLE, LOAD, LAUNCH, RUN, DONE.
REQ-017 IDLE: on start=1, num_layers and first_buf1 SHALL be latched, layer_idx cleared, error/timeout cleared, and the FSM SHALL go to LOAD; if latched num_layers=0, it SHALL go to DONE instead.
REQ-018 LOAD (1 cycle): the FSM SHALL read table[layer_idx]. Type 00 SHALL set error and go to IDLE without launching. Otherwise it SHALL go to LAUNCH.
REQ-019 LAUNCH (1 cycle): layer_start SHALL be 1, and comp_sel/aybz_azby SHALL present the layer's values. The FSM SHALL then go to RUN.
REQ-020 RUN: comp_sel and aybz_azby SHALL be held stable. On layer_done=1 the driver buffer SHALL toggle. If layer_idx = num_layers-1, the FSM SHALL go to DONE; otherwise layer_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-021 layer_done SHALL be ignored in every state except RUN.
REQ-022 aybz_azby encoding: bit1 = 1 for DENSE, 0 for CONV/POOL; bit0 = 1 when BUF1 is the driver.
REQ-023 The driver for layer 0 SHALL be first_buf1, and the driver SHALL invert for each subsequent layer.
REQ-024 In IDLE, LOAD and DONE, comp_sel SHALL be 000 and aybz_azby SHALL be 01, so at least one idle cycle separates consecutive layers.
REQ-025 DONE (1 cycle): done SHALL be 1, then the FSM SHALL go to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 start while busy=1 SHALL be ignored.
REQ-028 Latency: start at cycle t SHALL give LOAD at t+1 and layer_start at t+2. layer_done at cycle u SHALL give the next layer_start at u+2, or done at u+1 for the last layer.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst=1 SHALL force IDLE from any state, including mid-RUN. Outputs SHALL reset to comp_sel=000, aybz_azby=01, layer_start=0, layer_idx=0, busy=0, done=0, error=0, timeout=0.
REQ-031 Layer-table contents SHALL NOT be affected by reset.

Configuration
REQ-032 With SEQ_TIMEOUT_EN defined, a 16-bit counter SHALL clear on entry to RUN and increment every RUN cycle. When it reaches 0xFFFF without layer_done, timeout SHALL be set and the FSM SHALL go to IDLE without asserting done.
REQ-033 Without SEQ_TIMEOUT_EN, no counter SHALL exist, timeout SHALL be tied to 0, and RUN SHALL wait indefinitely.

Verification
REQ-034 Table {CONV, POOL, DENSE}, num_layers=3, first_buf1=1, start, layer_done 10 cycles after each layer_start -> (comp_sel, aybz_azby) = (001,01), (011,00), (010,11); each layer_start spaced 12 cycles apart; done one cycle after the third layer_done.
REQ-035 Same table with first_buf1=0 -> aybz_azby sequence 00, 01, 10.
REQ-036 num_layers=0, start -> done at t+1, no layer_start, comp_sel stays 000.
REQ-037 table[1]=00, num_layers=4 -> layer 0 runs; error=1 after the LOAD of layer 1; busy drops; done never asserted.
REQ-038 rst during RUN of layer 2, then start -> all outputs at reset values after rst; the new run starts from layer_idx=0; the table is unchanged.
REQ-039 With SEQ_TIMEOUT_EN and no layer_done -> timeout=1 after 65535 RUN cycles, FSM in IDLE; without the macro -> busy remains 1.

Source files
------------

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks a 32-entry layer table, launching conv/dense/pool controllers with ping-pong buffer routing.
// Latency: start -> layer_start in 2 cycles; layer_done -> next layer_start in 2 cycles, or done in 1 cycle for the last layer.
// Backpressure: none; start is ignored while busy and layer_done is honoured only in RUN. Optional SEQ_TIMEOUT_EN adds a RUN watchdog.
module layer_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_we,
    input  logic [4:0] cfg_addr,
    input  logic [1:0] cfg_type,
    input  logic [5:0] num_layers,
    input  logic       first_buf1,
    input  logic       start,
    input  logic       layer_done,
    output logic [2:0] comp_sel,
    output logic [1:0] aybz_azby,
    output logic       layer_start,
    output logic [4:0] layer_idx,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       timeout
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_RUN, S_DONE} state_t;

    localparam logic [1:0] TYPE_INVALID = 2'b00;
    localparam logic [1:0] TYPE_DENSE   = 2'b10;

    state_t     state, state_nxt;
    logic [1:0] table_q [32];
    logic [5:0] nl_q;
    logic [5:0] nl_in;
    logic       drv_q;
    logic [1:0] cur_type;
    logic       last_layer;
    logic       run_tmo;

    assign nl_in      = (num_layers > 6'd32) ? 6'd32 : num_layers;
    assign cur_type   = table_q[layer_idx];
    assign last_layer = ({1'b0, layer_idx} == (nl_q - 6'd1));

`ifdef SEQ_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        timeout_q;

    // The increment that would take the counter to 0xFFFF aborts the layer instead.
    assign run_tmo = (state == S_RUN) && !layer_done && (tmo_cnt == 16'hFFFE);
    assign timeout = timeout_q;

    // RUN watchdog: cleared while launching, counts RUN cycles, sticky flag until next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt   <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            if (state == S_LAUNCH)
                tmo_cnt <= 16'd0;
            else if (state == S_RUN)
                tmo_cnt <= tmo_cnt + 16'd1;
            if (state == S_IDLE && start)
                timeout_q <= 1'b0;
            else if (run_tmo)
                timeout_q <= 1'b1;
        end
    end
`else
    assign run_tmo = 1'b0;
    assign timeout = 1'b0;
`endif

    // Layer table: writable only while idle, deliberately untouched by reset.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy)
            table_q[cfg_addr] <= cfg_type;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = (nl_in == 6'd0) ? S_DONE : S_LOAD;
            S_LOAD:   state_nxt = (cur_type == TYPE_INVALID) ? S_IDLE : S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN: begin
                if (layer_done)
                    state_nxt = last_layer ? S_DONE : S_LOAD;
                else if (run_tmo)
                    state_nxt = S_IDLE;
            end
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register plus outputs registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            comp_sel    <= 3'b000;
            aybz_azby   <= 2'b01;
            layer_start <= 1'b0;
            layer_idx   <= 5'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            nl_q        <= 6'd0;
            drv_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            busy        <= (state_nxt != S_IDLE);
            done        <= (state_nxt == S_DONE);
            layer_start <= (state_nxt == S_LAUNCH);

            if (state_nxt == S_LAUNCH) begin
                // Type codes 01/10/11 map directly onto comp_sel 001/010/011.
                comp_sel  <= {1'b0, cur_type};
                aybz_azby <= {cur_type == TYPE_DENSE, drv_q};
            end else if (state_nxt != S_RUN) begin
                comp_sel  <= 3'b000;
                aybz_azby <= 2'b01;
            end

            if (state == S_IDLE && start) begin
                nl_q      <= nl_in;
                drv_q     <= first_buf1;
                layer_idx <= 5'd0;
                error     <= 1'b0;
            end

            if (state == S_LOAD && cur_type == TYPE_INVALID)
                error <= 1'b1;

            if (state == S_RUN && layer_done) begin
                drv_q <= ~drv_q;
                if (!last_layer)
                    layer_idx <= layer_idx + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: ping-pong sequencing, zero/clamped layer counts, invalid type, reset mid-run, stall.
// Latency: inputs driven 1ns after the rising edge, outputs sampled in the same window.
// Backpressure: none; layer_done is pulsed by the bench as the controller model.
module tb_layer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_we;
    logic [4:0] cfg_addr;
    logic [1:0] cfg_type;
    logic [5:0] num_layers;
    logic       first_buf1;
    logic       start;
    logic       layer_done;
    logic [2:0] comp_sel;
    logic [1:0] aybz_azby;
    logic       layer_start;
    logic [4:0] layer_idx;
    logic       busy;
    logic       done;
    logic       error;
    logic       timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    layer_sequencer dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_type(cfg_type),
        .num_layers(num_layers), .first_buf1(first_buf1), .start(start), .layer_done(layer_done),
        .comp_sel(comp_sel), .aybz_azby(aybz_azby), .layer_start(layer_start), .layer_idx(layer_idx),
        .busy(busy), .done(done), .error(error), .timeout(timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [4:0] a, input logic [1:0] t);
        cfg_we = 1'b1; cfg_addr = a; cfg_type = t;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_layer_start(input int bound);
        int n = 0;
        while (layer_start !== 1'b1 && n < bound) begin tick(); n++; end
    endtask

    task automatic test_reset();
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = 5'd0; cfg_type = 2'b00;
        num_layers = 6'd0; first_buf1 = 1'b0; start = 1'b0; layer_done = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++;
        if ({comp_sel, aybz_azby, layer_start, layer_idx, busy, done, error, timeout} !== {3'b000, 2'b01, 1'b0, 5'd0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%b_%b_%0d_%b%b%b%b exp=000_01_0_0_0000",
                     comp_sel, aybz_azby, layer_start, layer_idx, busy, done, error, timeout);
        end
    endtask

    // Three layers CONV, POOL, DENSE; controller model finishes 10 cycles after each launch.
    task automatic test_ping_pong(input logic fb1, input logic [5:0] exp_a);
        logic [8:0] exp_c;
        int t, s, s_prev;
        exp_c = {3'b001, 3'b011, 3'b010};
        num_layers = 6'd3; first_buf1 = fb1; start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || layer_start !== 1'b0) begin
            bad++; $display("FAIL pp%0d_load busy=%b ls=%b exp busy=1 ls=0", fb1, busy, layer_start);
        end
        s_prev = t;
        for (int i = 0; i < 3; i++) begin
            wait_layer_start(20);
            s = cyc;
            total++;
            if (layer_start !== 1'b1) begin
                bad++; $display("FAIL pp%0d_start%0d got=%b exp=1", fb1, i, layer_start);
            end
            total++;
            if ((s - s_prev) !== ((i == 0) ? 2 : 12)) begin
                bad++; $display("FAIL pp%0d_spacing%0d got=%0d exp=%0d", fb1, i, s - s_prev, (i == 0) ? 2 : 12);
            end
            total++;
            if (comp_sel !== exp_c[8-3*i -: 3] || aybz_azby !== exp_a[5-2*i -: 2] || layer_idx !== i[4:0]) begin
                bad++;
                $display("FAIL pp%0d_layer%0d got sel=%b ab=%b idx=%0d exp sel=%b ab=%b idx=%0d",
                         fb1, i, comp_sel, aybz_azby, layer_idx, exp_c[8-3*i -: 3], exp_a[5-2*i -: 2], i);
            end
            repeat (5) tick();
            total++;
            if (comp_sel !== exp_c[8-3*i -: 3] || aybz_azby !== exp_a[5-2*i -: 2] || layer_start !== 1'b0) begin
                bad++; $display("FAIL pp%0d_hold%0d got sel=%b ab=%b ls=%b", fb1, i, comp_sel, aybz_azby, layer_start);
            end
            repeat (5) tick();
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
            s_prev = s;
        end
        total++;
        if (done !== 1'b1 || comp_sel !== 3'b000 || aybz_azby !== 2'b01) begin
            bad++; $display("FAIL pp%0d_done got done=%b sel=%b ab=%b exp 1/000/01", fb1, done, comp_sel, aybz_azby);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL pp%0d_idle got done=%b busy=%b exp 0/0", fb1, done, busy);
        end
    endtask

    task automatic test_zero_layers();
        num_layers = 6'd0; start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || layer_start !== 1'b0 || comp_sel !== 3'b000 || busy !== 1'b1) begin
            bad++; $display("FAIL zero_done got done=%b ls=%b sel=%b busy=%b exp 1/0/000/1", done, layer_start, comp_sel, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || layer_start !== 1'b0) begin
            bad++; $display("FAIL zero_after got done=%b busy=%b ls=%b exp 0/0/0", done, busy, layer_start);
        end
    endtask

    // num_layers above 32 runs exactly 32 layers; done arrives with layer_idx=31.
    task automatic test_clamp();
        int cnt = 0, n = 0;
        logic got_done = 1'b0, prev_ls = 1'b0;
        logic [4:0] idx_at_done = 5'd0;
        for (int a = 3; a < 32; a++) cfg_write(a[4:0], 2'b01);
        num_layers = 6'd40; first_buf1 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        while (!got_done && n < 1000) begin
            layer_done = prev_ls;
            prev_ls = layer_start;
            if (layer_start === 1'b1) cnt++;
            if (done === 1'b1) begin got_done = 1'b1; idx_at_done = layer_idx; end
            tick();
            n++;
        end
        layer_done = 1'b0;
        total++;
        if (cnt !== 32 || got_done !== 1'b1 || idx_at_done !== 5'd31) begin
            bad++; $display("FAIL clamp got starts=%0d done=%b idx=%0d exp 32/1/31", cnt, got_done, idx_at_done);
        end
        tick();
    endtask

    task automatic test_bad_type();
        logic saw = 1'b0;
        cfg_write(5'd1, 2'b00);
        num_layers = 6'd4; first_buf1 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        wait_layer_start(10);
        total++;
        if (layer_start !== 1'b1 || comp_sel !== 3'b001) begin
            bad++; $display("FAIL badtype_layer0 got ls=%b sel=%b exp 1/001", layer_start, comp_sel);
        end
        tick();
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL badtype_load got err=%b busy=%b exp 0/1", error, busy);
        end
        tick();
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || comp_sel !== 3'b000) begin
            bad++; $display("FAIL badtype_err got err=%b busy=%b sel=%b exp 1/0/000", error, busy, comp_sel);
        end
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1 || layer_start === 1'b1) saw = 1'b1;
            tick();
        end
        total++;
        if (saw !== 1'b0 || error !== 1'b1) begin
            bad++; $display("FAIL badtype_quiet got pulse=%b err=%b exp 0/1", saw, error);
        end
        cfg_write(5'd1, 2'b11);
    endtask

    task automatic test_reset_mid_run();
        num_layers = 6'd3; first_buf1 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_layer_start(10);
            tick();
            layer_done = 1'b1;
            tick();
            layer_done = 1'b0;
        end
        wait_layer_start(10);
        tick();
        cfg_write(5'd0, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || comp_sel !== 3'b010 || aybz_azby !== 2'b10 || layer_idx !== 5'd2) begin
            bad++; $display("FAIL midrun_hold got busy=%b sel=%b ab=%b idx=%0d exp 1/010/10/2", busy, comp_sel, aybz_azby, layer_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({comp_sel, aybz_azby, layer_start, layer_idx, busy, done, error, timeout} !== {3'b000, 2'b01, 1'b0, 5'd0, 4'b0000}) begin
            bad++;
            $display("FAIL midrun_reset got=%b_%b_%b_%0d_%b%b%b%b exp=000_01_0_0_0000",
                     comp_sel, aybz_azby, layer_start, layer_idx, busy, done, error, timeout);
        end
        first_buf1 = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        layer_done = 1'b1;
        tick();
        layer_done = 1'b0;
        total++;
        if (layer_start !== 1'b1 || comp_sel !== 3'b001 || aybz_azby !== 2'b01 || layer_idx !== 5'd0) begin
            bad++; $display("FAIL midrun_restart got ls=%b sel=%b ab=%b idx=%0d exp 1/001/01/0", layer_start, comp_sel, aybz_azby, layer_idx);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        num_layers = 6'd1; first_buf1 = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_layer_start(10);
        repeat (200) tick();
        total++;
        if (busy !== 1'b1 || comp_sel !== 3'b001 || aybz_azby !== 2'b00 || timeout !== 1'b0) begin
            bad++; $display("FAIL stall_wait got busy=%b sel=%b ab=%b to=%b exp 1/001/00/0", busy, comp_sel, aybz_azby, timeout);
        end
`ifdef SEQ_TIMEOUT_EN
        begin
            int n = 0;
            logic saw_done = 1'b0;
            while (busy === 1'b1 && n < 70000) begin
                if (done === 1'b1) saw_done = 1'b1;
                tick();
                n++;
            end
            total++;
            if (busy !== 1'b0 || timeout !== 1'b1 || saw_done !== 1'b0) begin
                bad++; $display("FAIL stall_timeout got busy=%b to=%b done_seen=%b exp 0/1/0", busy, timeout, saw_done);
            end
        end
`else
        repeat (1000) tick();
        total++;
        if (busy !== 1'b1 || timeout !== 1'b0) begin
            bad++; $display("FAIL stall_forever got busy=%b to=%b exp 1/0", busy, timeout);
        end
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        cfg_write(5'd0, 2'b01);
        cfg_write(5'd1, 2'b11);
        cfg_write(5'd2, 2'b10);
        test_ping_pong(1'b1, {2'b01, 2'b00, 2'b11});
        test_ping_pong(1'b0, {2'b00, 2'b01, 2'b10});
        test_zero_layers();
        test_clamp();
        test_bad_type();
        test_reset_mid_run();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
